// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: FSM states and counter widths.
package spi_pkg;

    localparam int unsigned SPI_WIDTH_DEFAULT = 8;
    localparam int unsigned SPI_CNT_W         = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } spi_state_e;

endpackage

// File: rtl/nbit_spi_rx_shifter.sv
// Bit counter and MSB-first shift register; flags the cycle in which a byte's last bit arrives.
module nbit_spi_rx_shifter
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH_DEFAULT
) (
    input  logic             i_SCK,
    input  logic             i_RST,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_byte,
    output logic             o_done,
    output logic             o_mid_byte
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [BW-1:0]    bit_cnt_q, bit_cnt_d, cnt_base;
    logic [WIDTH-2:0] sr_q, sr_d;

    // The completed byte is formed combinationally so the top can latch it on the last bit.
    always_comb begin
        cnt_base  = i_clear ? '0 : bit_cnt_q;
        bit_cnt_d = cnt_base;
        sr_d      = sr_q;
        o_done    = 1'b0;
        o_byte    = {sr_q, i_bit};
        if (i_shift) begin
            sr_d = o_byte[WIDTH-2:0];
            if (cnt_base == BW'(WIDTH - 1)) begin
                o_done    = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = cnt_base + 1'b1;
            end
        end
    end

    assign o_mid_byte = (bit_cnt_q != '0);

    always_ff @(posedge i_SCK or negedge i_RST) begin
        if (!i_RST) begin
            bit_cnt_q <= '0;
            sr_q      <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
        end
    end

endmodule

// File: rtl/nbit_spi_rx_buffer.sv
// Multi-byte SPI receiver: frame FSM, packed frame buffer, per-byte D/C flags and status.
// Define SPI_RX_GAP_EN to let frames span CS-high gaps shorter than GAP_CYCLES.
module nbit_spi_rx_buffer
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH      = SPI_WIDTH_DEFAULT,
    parameter int unsigned N          = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                 i_SCK,
    input  logic                 i_RST,
    input  logic                 i_MOSI,
    input  logic                 i_CS,
    input  logic                 i_DC,
    output logic [WIDTH*N-1:0]   o_DATA,
    output logic [N-1:0]         o_DC,
    output logic [WIDTH-1:0]     o_BYTE,
    output logic                 o_BYTE_VALID,
    output logic [SPI_CNT_W-1:0] o_N_received,
    output logic                 o_FRAME_DONE,
    output logic                 o_FRAME_ERR,
    output logic                 o_OVERFLOW
);

    if (WIDTH < 2 || N < 1 || N > 31 || GAP_CYCLES < 1) begin : g_bad_param
        $error("nbit_spi_rx_buffer: unsupported parameter set");
    end

    spi_state_e           state_q, state_d;
    logic [SPI_CNT_W-1:0] n_q, n_d;
    logic [WIDTH*N-1:0]   data_q, data_d;
    logic [N-1:0]         dc_q, dc_d;
    logic [WIDTH-1:0]     byte_q, byte_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;

    logic             sh_clear, sh_shift, sh_done, sh_mid;
    logic [WIDTH-1:0] sh_byte;

`ifdef SPI_RX_GAP_EN
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

    nbit_spi_rx_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .i_SCK      (i_SCK),
        .i_RST      (i_RST),
        .i_clear    (sh_clear),
        .i_shift    (sh_shift),
        .i_bit      (i_MOSI),
        .o_byte     (sh_byte),
        .o_done     (sh_done),
        .o_mid_byte (sh_mid)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        data_d       = data_q;
        dc_d         = dc_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        overflow_d   = overflow_q;
        sh_clear     = 1'b0;
        sh_shift     = 1'b0;
`ifdef SPI_RX_GAP_EN
        gap_cnt_d    = gap_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (!i_CS) begin
                    n_d         = '0;
                    data_d      = '0;
                    dc_d        = '0;
                    frame_err_d = 1'b0;
                    overflow_d  = 1'b0;
                    sh_clear    = 1'b1;
                    sh_shift    = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (!i_CS) begin
                    sh_shift = 1'b1;
                end else begin
                    if (sh_mid) begin
                        frame_err_d = 1'b1;
                        sh_clear    = 1'b1;
                    end
`ifdef SPI_RX_GAP_EN
                    if (GAP_CYCLES <= 1) begin
                        frame_done_d = (n_q != '0);
                        state_d      = IDLE;
                    end else begin
                        gap_cnt_d = GW'(1);
                        state_d   = GAP;
                    end
`else
                    frame_done_d = (n_q != '0);
                    state_d      = IDLE;
`endif
                end
            end
`ifdef SPI_RX_GAP_EN
            GAP: begin
                if (!i_CS) begin
                    sh_shift  = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = SHIFT;
                end else if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    frame_done_d = (n_q != '0);
                    state_d      = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Slot index uses n_d so a byte completing on the frame's first cycle lands in slot 0.
        if (sh_done) begin
            byte_d       = sh_byte;
            byte_valid_d = 1'b1;
            if (n_d < SPI_CNT_W'(N)) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (n_d == SPI_CNT_W'(i)) begin
                        data_d[WIDTH*(N-i)-1 -: WIDTH] = sh_byte;
                        dc_d[N-1-i]                    = i_DC;
                    end
                end
                n_d = n_d + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_SCK or negedge i_RST) begin
        if (!i_RST) begin
            state_q      <= IDLE;
            n_q          <= '0;
            data_q       <= '0;
            dc_q         <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef SPI_RX_GAP_EN
            gap_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            data_q       <= data_d;
            dc_q         <= dc_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
`ifdef SPI_RX_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    assign o_DATA       = data_q;
    assign o_DC         = dc_q;
    assign o_BYTE       = byte_q;
    assign o_BYTE_VALID = byte_valid_q;
    assign o_N_received = n_q;
    assign o_FRAME_DONE = frame_done_q;
    assign o_FRAME_ERR  = frame_err_q;
    assign o_OVERFLOW   = overflow_q;

endmodule
